// File: rtl/sum_shift_accumulator.sv
// sum_shift_accumulator
// Absorbs a stream of 5-bit adder results. Each result is left-shifted by its
// own amount and added into a wide accumulator. When the beat flagged `last`
// has been absorbed, the frame total is offered on a valid/ready output.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ACCUM | accepting beats, accumulator shows the running frame total
// ST_DONE  | frame complete, result held until the downstream takes it
module sum_shift_accumulator #(
    parameter int ACC_W = 16,
    parameter int SH_W  = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_sum,
    input  logic [SH_W-1:0]  in_shamt,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    // Wide enough that the largest shift never drops a set bit of in_sum,
    // so any bit pushed past the accumulator is seen by the overflow check.
    localparam int EXT_W = ACC_W + (1 << SH_W);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;

    logic [EXT_W-1:0] w_ext;
    logic [EXT_W-1:0] w_shifted;
    logic [ACC_W-1:0] w_addend;
    logic             w_shift_ovf;
    logic [ACC_W:0]   w_sum;
    logic             w_beat;
    logic             w_out_fire;
    logic             w_count_max;

    // Shift the zero-extended input; anything above the accumulator is overflow.
    // A shift of ACC_W or more lands every input bit in the upper field, which
    // gives a zero addend and flags overflow exactly when in_sum is nonzero.
    always_comb begin
        w_ext       = {{(EXT_W-5){1'b0}}, in_sum};
        w_shifted   = w_ext << in_shamt;
        w_addend    = w_shifted[ACC_W-1:0];
        w_shift_ovf = |w_shifted[EXT_W-1:ACC_W];
        w_sum       = {1'b0, r_acc} + {1'b0, w_addend};
        w_count_max = &r_count;
        w_beat      = in_valid & in_ready;
        w_out_fire  = out_valid & out_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACCUM: if (w_beat && in_last) w_state_next = ST_DONE;
            ST_DONE:  if (w_out_fire)        w_state_next = ST_ACCUM;
            default:  w_state_next = ST_ACCUM;
        endcase
    end

    // Handshake outputs come from state only; in_ready is also held low in reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_ACCUM: in_ready  = rst_n;
            ST_DONE:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Accumulator, sticky overflow and saturating beat count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_beat) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_shift_ovf | w_sum[ACC_W];
            if (!w_count_max) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (w_out_fire) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end
    end

    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;
    assign out_count = r_count;

endmodule

// File: tb/tb_sum_shift_accumulator.sv
// Bench for sum_shift_accumulator: directed vector table, hand-written
// reset/backpressure/saturation sequences, then random traffic against a
// frame-level arithmetic model.
module tb_sum_shift_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_sum;
    logic [3:0]  in_shamt;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_acc;
    logic        out_ovf;
    logic [3:0]  out_count;

    int errors = 0;
    int checks = 0;

    sum_shift_accumulator #(.ACC_W(16), .SH_W(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_shamt  (in_shamt),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  sum;
        logic [3:0]  sh;
        logic        last;
        logic [15:0] e_acc;
        logic        e_ovf;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[6];

    // Frame-level reference: plain integer arithmetic on the spec's rules.
    longint m_acc;
    bit     m_ovf;
    int     m_cnt;
    bit     m_done;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_ovf = 0;
        m_cnt = 0;
        m_done = 0;
    endtask

    task automatic model_beat(input int s, input int sh);
        longint prod;
        longint tot;
        prod = longint'(s) << sh;
        if ((prod >> 16) != 0) m_ovf = 1;
        tot = m_acc + (prod % 65536);
        if (tot >= 65536) m_ovf = 1;
        m_acc = tot % 65536;
        if (m_cnt < 15) m_cnt++;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".acc"},       longint'(out_acc),   m_acc);
        chk({tag, ".ovf"},       longint'(out_ovf),   longint'(m_ovf));
        chk({tag, ".count"},     longint'(out_count), longint'(m_cnt));
        chk({tag, ".out_valid"}, longint'(out_valid), longint'(m_done));
        chk({tag, ".in_ready"},  longint'(in_ready),  longint'(!m_done));
    endtask

    task automatic beat(input int s, input int sh, input bit last);
        in_valid = 1'b1;
        in_sum   = 5'(s);
        in_shamt = 4'(sh);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        bit saw_valid;
        longint held_acc;
        longint held_cnt;

        vecs[0] = '{5'd5,  4'd0,  1'b0, 16'h0005, 1'b0, 4'd1};
        vecs[1] = '{5'd3,  4'd2,  1'b0, 16'h0011, 1'b0, 4'd2};
        vecs[2] = '{5'd1,  4'd4,  1'b1, 16'h0021, 1'b0, 4'd3};
        vecs[3] = '{5'h1F, 4'd15, 1'b1, 16'h8000, 1'b1, 4'd1};
        vecs[4] = '{5'h10, 4'd11, 1'b0, 16'h8000, 1'b0, 4'd1};
        vecs[5] = '{5'h10, 4'd11, 1'b1, 16'h0000, 1'b1, 4'd2};

        rst_n = 1'b0; in_valid = 1'b1; in_sum = 5'd3; in_shamt = 4'd1;
        in_last = 1'b0; out_ready = 1'b1;

        // Reset held with in_valid high: nothing accepted.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst.in_ready",  longint'(in_ready),  0);
            chk("rst.out_valid", longint'(out_valid), 0);
            chk("rst.acc",       longint'(out_acc),   0);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rel.in_ready", longint'(in_ready),  1);
        chk("rel.acc",      longint'(out_acc),   0);
        chk("rel.count",    longint'(out_count), 0);

        // Directed vector table with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            beat(vecs[i].sum, vecs[i].sh, vecs[i].last);
            chk("vec.acc",       longint'(out_acc),   longint'(vecs[i].e_acc));
            chk("vec.ovf",       longint'(out_ovf),   longint'(vecs[i].e_ovf));
            chk("vec.count",     longint'(out_count), longint'(vecs[i].e_cnt));
            chk("vec.out_valid", longint'(out_valid), longint'(vecs[i].last));
            chk("vec.in_ready",  longint'(in_ready),  longint'(!vecs[i].last));
            if (vecs[i].last) begin
                tick();
                chk("vec.bubble.out_valid", longint'(out_valid), 0);
                chk("vec.bubble.in_ready",  longint'(in_ready),  1);
                chk("vec.bubble.acc",       longint'(out_acc),   0);
                chk("vec.bubble.count",     longint'(out_count), 0);
            end
        end

        // Backpressure: result held, incoming beats ignored.
        out_ready = 1'b0;
        beat(7, 1, 1'b1);
        held_acc = 14;
        held_cnt = 1;
        in_valid = 1'b1; in_sum = 5'd1; in_shamt = 4'd0; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.out_valid", longint'(out_valid), 1);
            chk("bp.in_ready",  longint'(in_ready),  0);
            chk("bp.acc",       longint'(out_acc),   held_acc);
            chk("bp.count",     longint'(out_count), held_cnt);
            chk("bp.ovf",       longint'(out_ovf),   0);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp.rel.out_valid", longint'(out_valid), 0);
        chk("bp.rel.in_ready",  longint'(in_ready),  1);
        chk("bp.rel.acc",       longint'(out_acc),   0);

        // Count saturation over a 20-beat frame.
        for (int i = 0; i < 20; i++) beat(1, 0, i == 19);
        chk("sat.out_valid", longint'(out_valid), 1);
        chk("sat.acc",       longint'(out_acc),   20);
        chk("sat.count",     longint'(out_count), 15);
        tick();

        // Mid-frame reset discards the partial frame with no output pulse.
        saw_valid = 0;
        beat(9, 3, 1'b0);
        beat(2, 1, 1'b0);
        chk("mid.acc.pre", longint'(out_acc), 76);
        rst_n = 1'b0;
        #1;
        chk("mid.in_ready.rst", longint'(in_ready), 0);
        tick();
        saw_valid |= out_valid;
        chk("mid.acc",   longint'(out_acc),   0);
        chk("mid.count", longint'(out_count), 0);
        rst_n = 1'b1;
        tick();
        saw_valid |= out_valid;
        chk("mid.no_valid", longint'(saw_valid), 0);
        chk("mid.in_ready", longint'(in_ready), 1);

        // Random traffic against the model, including backpressure and gaps.
        model_clear();
        for (int c = 0; c < 3000; c++) begin
            int s;
            int sh;
            bit v;
            bit lst;
            bit rdy;
            v   = ($urandom_range(0, 3) != 0);
            s   = $urandom_range(0, 31);
            sh  = $urandom_range(0, 15);
            lst = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            in_valid = v; in_sum = 5'(s); in_shamt = 4'(sh);
            in_last = lst; out_ready = rdy;
            if (!m_done) begin
                if (v) begin
                    model_beat(s, sh);
                    if (lst) m_done = 1;
                end
            end else if (rdy) begin
                model_clear();
            end
            tick();
            check_model("rnd");
        end

        in_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
